// File: rtl/inst_rom_ld.sv
// Instruction memory for the core fetch port, filled at run time by a byte-serial
// big-endian loader. Define INST_ROM_LOAD_CHK_EN to treat the ld_last byte as a checksum.
module inst_rom_ld #(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [31:0]           addr,
    output logic [31:0]           inst_o,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_byte,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  ld_done,
    output logic                  ld_err,
    output logic [DEPTH_LOG2:0]   ld_words
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t              state;
    logic [31:0]         mem [DEPTH];
    logic [DEPTH_LOG2:0] wptr;
    logic [1:0]          byte_cnt;
    logic [31:0]         asm_word;
    logic                ready_r;
    logic                done_r;
    logic                err_r;

    logic                accept;
    logic                is_data;
    logic                full;
    logic                word_wr;
    logic [31:0]         merged;
    logic [31:0]         wr_data;

`ifdef INST_ROM_LOAD_CHK_EN
    logic [7:0]          sum;
`endif

    // Unused high/low fetch address bits: the address simply wraps.
    logic unused_addr;
    assign unused_addr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

    always_comb begin
        accept  = (state == LOAD) && ld_valid;
`ifdef INST_ROM_LOAD_CHK_EN
        is_data = accept && !ld_last;
`else
        is_data = accept;
`endif
        full    = wptr[DEPTH_LOG2];
        merged  = asm_word | ({ld_byte, 24'b0} >> {byte_cnt, 3'b000});
        // A write happens on a completed word, or on ld_last when anything is pending.
        word_wr = (is_data && (byte_cnt == 2'd3)) ||
                  (accept && ld_last && (is_data || (byte_cnt != 2'd0)));
        wr_data = is_data ? merged : asm_word;
    end

    always_ff @(posedge clk) begin
        if (word_wr && !full)
            mem[wptr[DEPTH_LOG2-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wptr     <= '0;
            byte_cnt <= '0;
            asm_word <= '0;
            ready_r  <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
`ifdef INST_ROM_LOAD_CHK_EN
            sum      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (ld_start) begin
                        state    <= LOAD;
                        ready_r  <= 1'b1;
                        wptr     <= '0;
                        byte_cnt <= '0;
                        asm_word <= '0;
                        err_r    <= 1'b0;
`ifdef INST_ROM_LOAD_CHK_EN
                        sum      <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (accept) begin
`ifdef INST_ROM_LOAD_CHK_EN
                        if (is_data)
                            sum <= sum + ld_byte;
                        if (ld_last && (sum != ld_byte))
                            err_r <= 1'b1;
`endif
                        if (word_wr) begin
                            asm_word <= '0;
                            byte_cnt <= '0;
                            if (full)
                                err_r <= 1'b1;
                            else
                                wptr <= wptr + (DEPTH_LOG2+1)'(1);
                        end else if (is_data) begin
                            asm_word <= merged;
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                        if (ld_last) begin
                            state   <= DONE;
                            ready_r <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ld_ready = ready_r;
    assign ld_done  = done_r;
    assign ld_err   = err_r;
    assign ld_words = wptr;
    assign inst_o   = (ce && (state != LOAD) && !rst) ? mem[addr[DEPTH_LOG2+1:2]] : '0;

endmodule

// File: tb/tb_inst_rom_ld.sv
// Scoreboard bench for inst_rom_ld: session results are queued by the stimulus and
// popped by a monitor on ld_done; stored words are checked through the fetch port.
module tb_inst_rom_ld;

    localparam int unsigned DL    = 3;
    localparam int unsigned DEPTH = 1 << DL;
`ifdef INST_ROM_LOAD_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef logic [7:0] byte_t;
    typedef struct {
        int unsigned words;
        bit          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b0;
    logic [31:0]   addr = '0;
    logic [31:0]   inst_o;
    logic          ld_start = 1'b0;
    logic          ld_valid = 1'b0;
    logic [7:0]    ld_byte = '0;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic          ld_done;
    logic          ld_err;
    logic [DL:0]   ld_words;

    int unsigned   checks = 0;
    int unsigned   errors = 0;
    exp_t          exp_q[$];
    logic [31:0]   model_mem [DEPTH];
    bit            known [DEPTH];
    bit            prev_done = 1'b0;

    inst_rom_ld #(.DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst_o(inst_o),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_done(ld_done), .ld_err(ld_err), .ld_words(ld_words)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: a session is a byte list; data bytes pack big-endian into words from word 0.
    task automatic model_session(input byte_t b[$]);
        int unsigned n_data, nw;
        logic [7:0]  s;
        logic [31:0] w;
        exp_t        e;
        n_data = CHK ? b.size() - 1 : b.size();
        s = '0;
        for (int unsigned i = 0; i < n_data; i++) s = s + b[i];
        nw = (n_data + 3) / 4;
        for (int unsigned i = 0; i < nw; i++) begin
            w = '0;
            for (int unsigned j = 0; j < 4; j++)
                if (4*i + j < n_data) w[31-8*j -: 8] = b[4*i + j];
            if (i < DEPTH) begin
                model_mem[i] = w;
                known[i] = 1'b1;
            end
        end
        e.words = (nw > DEPTH) ? DEPTH : nw;
        e.err   = (nw > DEPTH) || (CHK && (s != b[b.size()-1]));
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ld_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(ld_done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ld_words", 32'(ld_words), e.words);
                    check("ld_err", 32'(ld_err), 32'(e.err));
                end
                if (prev_done) check("done_width", 32'(prev_done), 32'd0);
            end
            prev_done = ld_done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic send_byte(input byte_t b, input bit last);
        int unsigned gap, n;
        gap = $urandom_range(0, 2);
        ld_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        ld_valid = 1'b1; ld_byte = b; ld_last = last;
        n = 0;
        while (!ld_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!ld_ready) check("ready_timeout", 32'(ld_ready), 32'd1);
        else begin @(posedge clk); #1; end
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic fetch_check(input int unsigned idx, input string name);
        logic [31:0] a;
        a = $urandom;
        a[DL+1:2] = DL'(idx);
        ce = 1'b1; addr = a; #1;
        check(name, inst_o, model_mem[idx]);
        ce = 1'b0;
    endtask

    task automatic start_session();
        ce = 1'b1; addr = 32'h0;
        ld_start = 1'b1; #1;
        if (known[0]) check("fetch_on_start", inst_o, model_mem[0]);
        @(posedge clk); #1;
        ld_start = 1'b0;
        check("ready_after_start", 32'(ld_ready), 32'd1);
        check("words_cleared", 32'(ld_words), 32'd0);
        addr = $urandom; #1;
        check("fetch_in_load", inst_o, 32'd0);
        ce = 1'b0;
    endtask

    task automatic run_session(input byte_t b[$]);
        start_session();
        model_session(b);
        for (int unsigned i = 0; i < b.size(); i++)
            send_byte(b[i], i == b.size() - 1);
        @(negedge clk);
        @(posedge clk); #1;
        for (int unsigned i = 0; i < DEPTH; i++)
            if (known[i]) fetch_check(i, "fetch_word");
    endtask

    initial begin
        byte_t b[$];
        logic [7:0] s;
        for (int unsigned i = 0; i < DEPTH; i++) known[i] = 1'b0;

        ce = 1'b1; #2;
        check("rst_inst", inst_o, 32'd0);
        check("rst_ready", 32'(ld_ready), 32'd0);
        check("rst_done", 32'(ld_done), 32'd0);
        check("rst_err", 32'(ld_err), 32'd0);
        check("rst_words", 32'(ld_words), 32'd0);
        ce = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;

        b = '{8'h34, 8'h01, 8'h00, 8'h10, 8'h34, 8'h02, 8'h00, 8'h20};
        run_session(b);
        ce = 1'b0; addr = 32'h4; #1;
        check("ce_low_nop", inst_o, 32'd0);

        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAB};
        run_session(b);
        ce = 1'b1; addr = 32'h1000; #1;
        check("addr_wrap", inst_o, model_mem[0]);
        ce = 1'b0;

        b = '{};
        for (int unsigned i = 0; i < 4*DEPTH + 1; i++) b.push_back(byte_t'($urandom));
        run_session(b);

        b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        run_session(b);
        b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
        run_session(b);

        for (int k = 0; k < 20; k++) begin
            b = '{};
            repeat ($urandom_range(1, 4*DEPTH + 6)) b.push_back(byte_t'($urandom));
            if (CHK && ($urandom_range(0, 1) == 1)) begin
                s = '0;
                for (int unsigned i = 0; i + 1 < b.size(); i++) s = s + b[i];
                b[b.size()-1] = s;
            end
            run_session(b);
        end

        // Reset after 6 accepted bytes: word 0 was written, the partial word is lost.
        start_session();
        b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h55, 8'h66};
        for (int unsigned i = 0; i < b.size(); i++) send_byte(b[i], 1'b0);
        model_mem[0] = 32'hDEADBEEF; known[0] = 1'b1;
        rst = 1'b1; ce = 1'b1; addr = 32'h0; #1;
        check("midrst_inst", inst_o, 32'd0);
        check("midrst_ready", 32'(ld_ready), 32'd0);
        check("midrst_words", 32'(ld_words), 32'd0);
        check("midrst_done", 32'(ld_done), 32'd0);
        check("midrst_err", 32'(ld_err), 32'd0);
        @(posedge clk); #1; rst = 1'b0; #1;
        check("midrst_word0", inst_o, 32'hDEADBEEF);
        ce = 1'b0;
        @(posedge clk); #1;

        b = '{};
        for (int unsigned i = 0; i < 12; i++) b.push_back(byte_t'($urandom));
        run_session(b);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
